// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, receiver FSM states and
// elaboration-time helpers for baud and bit counter sizing.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic int calc_baud_max(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Ceiling log2, never below 1 so counters always have at least one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word delivery bundle between the UART receiver and the
// write-FIFO side of its consumer.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] po_data;
    logic                 po_flag;
    logic                 po_frame_err;
    logic                 po_parity_err;
    logic                 busy;

    modport master (output po_data, po_flag, po_frame_err, po_parity_err, busy);
    modport slave  (input  po_data, po_flag, po_frame_err, po_parity_err, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-stage synchroniser for the asynchronous rx line plus a history stage
// for falling-edge detection. All stages reset to 1 (idle line).
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-tap majority sampling, optional parity,
// 1 or 2 stop bits, start-glitch rejection and a break guard after framing errors.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int BAUD_MAX  = calc_baud_max(CLK_FREQ, BAUD_RATE),
    parameter int BAUD_HALF = BAUD_MAX / 2,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          rx,
    uart_rx_cfg_if.master rx_if
);

    localparam int CNT_W = clog2_min1(BAUD_MAX);
    localparam int BIT_W = clog2_min1(DATA_BITS);

    localparam logic [CNT_W-1:0] TAP_A     = CNT_W'(BAUD_HALF - 1);
    localparam logic [CNT_W-1:0] TAP_B     = CNT_W'(BAUD_HALF);
    localparam logic [CNT_W-1:0] TAP_C     = CNT_W'(BAUD_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_MAX - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic rx_s;
    logic rx_fall;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tap_a_q, tap_a_d;
    logic                 tap_b_q, tap_b_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 armed_q, armed_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] po_data_q, po_data_d;
    logic                 po_flag_q, po_flag_d;
    logic                 po_frame_err_q, po_frame_err_d;
    logic                 po_parity_err_q, po_parity_err_d;

    logic at_resolve;
    logic at_wrap;
    logic maj;
    logic par_exp;
    logic final_err;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .rx_s      (rx_s),
        .rx_fall   (rx_fall)
    );

    assign at_resolve = (baud_cnt_q == TAP_C);
    assign at_wrap    = (baud_cnt_q == CNT_LAST);
    assign maj        = (tap_a_q & tap_b_q) | (tap_a_q & rx_s) | (tap_b_q & rx_s);
    assign par_exp    = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;
    assign final_err  = frame_err_q | ~maj;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (armed_q && rx_fall) state_d = ST_START;
            ST_START:  if (at_resolve && maj)  state_d = ST_IDLE;
                       else if (at_wrap)       state_d = ST_DATA;
            ST_DATA:   if (at_wrap && bit_cnt_q == DATA_LAST)
                           state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (at_wrap) state_d = ST_STOP;
            // Leave on the final stop-bit resolve so the next start edge is never missed.
            ST_STOP:   if (at_resolve && bit_cnt_q == STOP_LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d      = baud_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        tap_a_d         = tap_a_q;
        tap_b_d         = tap_b_q;
        shift_d         = shift_q;
        frame_err_d     = frame_err_q;
        parity_err_d    = parity_err_q;
        armed_d         = armed_q;
        busy_d          = (state_d != ST_IDLE);
        po_data_d       = po_data_q;
        po_flag_d       = 1'b0;
        po_frame_err_d  = po_frame_err_q;
        po_parity_err_d = po_parity_err_q;

        if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
            if (armed_q) begin
                if (rx_fall) begin
                    baud_cnt_d   = '0;
                    frame_err_d  = 1'b0;
                    parity_err_d = 1'b0;
                end
            // Disarmed: demand one unbroken bit time of idle-high before re-arming.
            end else if (!rx_s) begin
                baud_cnt_d = '0;
            end else if (at_wrap) begin
                baud_cnt_d = '0;
                armed_d    = 1'b1;
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
            end
        end else begin
            baud_cnt_d = at_wrap ? '0 : baud_cnt_q + 1'b1;
            if (baud_cnt_q == TAP_A) tap_a_d = rx_s;
            if (baud_cnt_q == TAP_B) tap_b_d = rx_s;
            if (at_wrap) bit_cnt_d = (state_d != state_q) ? '0 : bit_cnt_q + 1'b1;
            if (state_d == ST_IDLE) baud_cnt_d = '0;

            if (at_resolve) begin
                case (state_q)
                    ST_DATA:   shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    ST_PARITY: if (maj != par_exp) parity_err_d = 1'b1;
                    ST_STOP: begin
                        if (!maj) frame_err_d = 1'b1;
                        if (bit_cnt_q == STOP_LAST) begin
                            po_flag_d       = 1'b1;
                            po_data_d       = shift_q;
                            po_frame_err_d  = final_err;
                            po_parity_err_d = parity_err_q;
                            armed_d         = ~final_err;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            tap_a_q         <= 1'b1;
            tap_b_q         <= 1'b1;
            shift_q         <= '0;
            frame_err_q     <= 1'b0;
            parity_err_q    <= 1'b0;
            armed_q         <= 1'b0;
            busy_q          <= 1'b0;
            po_data_q       <= '0;
            po_flag_q       <= 1'b0;
            po_frame_err_q  <= 1'b0;
            po_parity_err_q <= 1'b0;
        end else begin
            baud_cnt_q      <= baud_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            tap_a_q         <= tap_a_d;
            tap_b_q         <= tap_b_d;
            shift_q         <= shift_d;
            frame_err_q     <= frame_err_d;
            parity_err_q    <= parity_err_d;
            armed_q         <= armed_d;
            busy_q          <= busy_d;
            po_data_q       <= po_data_d;
            po_flag_q       <= po_flag_d;
            po_frame_err_q  <= po_frame_err_d;
            po_parity_err_q <= po_parity_err_d;
        end
    end

    assign rx_if.po_data       = po_data_q;
    assign rx_if.po_flag       = po_flag_q;
    assign rx_if.po_frame_err  = po_frame_err_q;
    assign rx_if.po_parity_err = po_parity_err_q;
    assign rx_if.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) on
// separate lines; a negedge monitor pops expected words on every po_flag.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 500_000;
    localparam int BAUD_RATE = 9600;
    localparam int BIT_CLKS  = 52;
    localparam int HALF      = 26;

    typedef struct packed {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_line [3];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   flags_seen [3];
    int   last_stop_cyc [3];
    exp_t sb_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) if8 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) ifp ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(1)) dut8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_line[0]), .rx_if(if8.master));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
                  .PARITY(PAR_EVEN), .STOP_BITS(1)) dutp (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_line[1]), .rx_if(ifp.master));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(2)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_line[2]), .rx_if(if2.master));

    // Output monitor: every po_flag is matched against the scoreboard.
    initial begin
        logic prev_flag [3];
        logic f;
        exp_t got;
        exp_t e;
        int   lat;
        for (int k = 0; k < 3; k++) prev_flag[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: begin f = if8.po_flag; got = {9'(if8.po_data), if8.po_frame_err, if8.po_parity_err}; end
                    1: begin f = ifp.po_flag; got = {9'(ifp.po_data), ifp.po_frame_err, ifp.po_parity_err}; end
                    default: begin f = if2.po_flag; got = {9'(if2.po_data), if2.po_frame_err, if2.po_parity_err}; end
                endcase
                if (f) begin
                    flags_seen[k]++;
                    lat = cyc - last_stop_cyc[k];
                    $display("dut%0d word data=0x%03h frame_err=%0b parity_err=%0b latency=%0d",
                             k, got.data, got.ferr, got.perr, lat);
                    n_cmp++;
                    if (prev_flag[k] !== 1'b0) begin
                        n_err++;
                        $display("FAIL flag_width dut%0d: po_flag high on consecutive cycles, required 1 cycle", k);
                    end
                    n_cmp++;
                    if (sb_q[k].size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_flag dut%0d: got data=0x%03h, required no strobe", k, got.data);
                    end else begin
                        e = sb_q[k].pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL word dut%0d: got data=0x%03h fe=%0b pe=%0b, required data=0x%03h fe=%0b pe=%0b",
                                     k, got.data, got.ferr, got.perr, e.data, e.ferr, e.perr);
                        end
                        n_cmp++;
                        if (lat < HALF + 4 || lat > HALF + 6) begin
                            n_err++;
                            $display("FAIL latency dut%0d: got %0d clocks after final stop start, required %0d..%0d",
                                     k, lat, HALF + 4, HALF + 6);
                        end
                    end
                end
                prev_flag[k] = f;
            end
        end
    end

    task automatic drive_bit(input int k, input logic v, input int n);
        rx_line[k] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [8:0] data, input int nbits,
                              input int par, input bit par_flip, input int nstop,
                              input logic stop_val, input bit expect_out, input bit spike3);
        logic p;
        exp_t e;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        if (par == PAR_ODD) p = ~p;
        if (par_flip) p = ~p;
        e.data = '0;
        for (int i = 0; i < nbits; i++) e.data[i] = data[i];
        e.ferr = ~stop_val;
        e.perr = par_flip && (par != PAR_NONE);
        if (expect_out) sb_q[k].push_back(e);
        drive_bit(k, 1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            if (spike3 && i == 3) begin
                drive_bit(k, data[i], HALF + 1);
                drive_bit(k, ~data[i], 1);
                drive_bit(k, data[i], BIT_CLKS - HALF - 2);
            end else begin
                drive_bit(k, data[i], BIT_CLKS);
            end
        end
        if (par != PAR_NONE) drive_bit(k, p, BIT_CLKS);
        for (int s = 0; s < nstop; s++) begin
            if (s == nstop - 1) last_stop_cyc[k] = cyc;
            drive_bit(k, stop_val, BIT_CLKS);
        end
        rx_line[k] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({if8.po_flag, if8.po_frame_err, if8.po_parity_err, if8.busy, if8.po_data} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut8: got flag/fe/pe/busy/data=%b, required all 0",
                     {if8.po_flag, if8.po_frame_err, if8.po_parity_err, if8.busy, if8.po_data});
        end
        n_cmp++;
        if ({ifp.po_flag, ifp.po_frame_err, ifp.po_parity_err, ifp.busy, ifp.po_data} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_dutp: got flag/fe/pe/busy/data=%b, required all 0",
                     {ifp.po_flag, ifp.po_frame_err, ifp.po_parity_err, ifp.busy, ifp.po_data});
        end
        n_cmp++;
        if ({if2.po_flag, if2.po_frame_err, if2.po_parity_err, if2.busy, if2.po_data} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut2: got flag/fe/pe/busy/data=%b, required all 0",
                     {if2.po_flag, if2.po_frame_err, if2.po_parity_err, if2.busy, if2.po_data});
        end
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base;
        base = flags_seen[0];
        send_frame(0, 9'h055, 8, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        send_frame(0, 9'h0A3, 8, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        send_frame(0, 9'h000, 8, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        send_frame(0, 9'h0FF, 8, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_cmp++;
        if (flags_seen[0] - base !== 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d strobes, required 4", flags_seen[0] - base);
        end
    endtask

    task automatic test_glitch();
        int  base;
        int  last_hi;
        bit  saw_busy;
        base     = flags_seen[0];
        last_hi  = -1;
        saw_busy = 1'b0;
        rx_line[0] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 9) rx_line[0] = 1'b1;
            if (if8.busy) begin
                saw_busy = 1'b1;
                last_hi  = i;
            end
        end
        n_cmp++;
        if (saw_busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_rise: got busy never high, required busy after start edge");
        end
        n_cmp++;
        if (last_hi < HALF || last_hi > HALF + 6) begin
            n_err++;
            $display("FAIL glitch_busy_drop: got last busy clock %0d, required %0d..%0d", last_hi, HALF, HALF + 6);
        end
        repeat (BIT_CLKS) @(negedge clk);
        n_cmp++;
        if (flags_seen[0] !== base) begin
            n_err++;
            $display("FAIL glitch_flag: got %0d strobes, required 0", flags_seen[0] - base);
        end
    endtask

    task automatic test_spike();
        send_frame(0, 9'h000, 8, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_break();
        int base;
        base = flags_seen[0];
        send_frame(0, 9'h03C, 8, PAR_NONE, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        drive_bit(0, 1'b0, 3 * BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS);
        send_frame(0, 9'h05A, 8, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_cmp++;
        if (flags_seen[0] - base !== 2) begin
            n_err++;
            $display("FAIL break_count: got %0d strobes, required 2", flags_seen[0] - base);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 9'h041, 7, PAR_EVEN, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        send_frame(1, 9'h041, 7, PAR_EVEN, 1'b1, 1, 1'b1, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = flags_seen[2];
        fork
            send_frame(2, 9'h012, 8, PAR_NONE, 1'b0, 2, 1'b1, 1'b0, 1'b0);
            begin
                repeat (BIT_CLKS * 6 + 20) @(negedge clk);
                n_cmp++;
                if (if2.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL midframe_busy: got %b, required 1", if2.busy);
                end
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if (if2.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL async_reset_busy: got %b, required 0", if2.busy);
                end
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        send_frame(2, 9'h034, 8, PAR_NONE, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_cmp++;
        if (flags_seen[2] - base !== 1) begin
            n_err++;
            $display("FAIL reset_mid_count: got %0d strobes, required 1", flags_seen[2] - base);
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (sb_q[k].size() !== 0) begin
                n_err++;
                $display("FAIL drain dut%0d: got %0d words outstanding, required 0", k, sb_q[k].size());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rx_line[k]       = 1'b1;
            flags_seen[k]    = 0;
            last_stop_cyc[k] = 0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_glitch();
        test_spike();
        test_break();
        test_parity();
        test_reset_mid_frame();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
